// File: rtl/wb_spi_regif.sv
// Wishbone classic slave for the SPI peripheral.
// DATA/CMD/STATUS registers with TX and RX FIFOs and sticky overflow flags.
module wb_spi_regif #(
  parameter int          DATA_W     = 10,
  parameter int          CMD_W      = 11,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       wb_addr,
  input  logic              wb_we,
  input  logic              wb_stb,
  input  logic              wb_cyc,
  input  logic [31:0]       wb_dout,
  output logic [31:0]       wb_din,
  output logic              wb_ack,
  output logic [CMD_W-1:0]  cfg,
  output logic              cfg_wr,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic sel, acc;
  logic hit_data, hit_cmd, hit_stat;
  logic wr_data, rd_data, wr_cmd, rd_stat;

  assign sel      = wb_stb & wb_cyc;
  assign acc      = sel & ~wb_ack;
  assign hit_data = (wb_addr == BASE_ADDR + 32'h10);
  assign hit_cmd  = (wb_addr == BASE_ADDR + 32'h20);
  assign hit_stat = (wb_addr == BASE_ADDR + 32'h30);
  assign wr_data  = acc & wb_we & hit_data;
  assign rd_data  = acc & ~wb_we & hit_data;
  assign wr_cmd   = acc & wb_we & hit_cmd;
  assign rd_stat  = acc & ~wb_we & hit_stat;

  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]     tx_wp, tx_rp;
  logic [CW-1:0]     tx_cnt;
  logic              tx_empty, tx_full, tx_push, tx_pop;

  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]     rx_wp, rx_rp;
  logic [CW-1:0]     rx_cnt;
  logic              rx_empty, rx_full, rx_push, rx_pop;

  logic tx_ovf, rx_ovf;

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));
  assign tx_pop   = ~tx_empty & tx_ready;
  // A full FIFO still takes a write when the head leaves on the same edge
  assign tx_push  = wr_data & (~tx_full | tx_pop);
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem[tx_rp];

  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(FIFO_DEPTH));
  assign rx_pop   = rd_data & ~rx_empty;
  assign rx_push  = rx_valid & (~rx_full | rx_pop);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wb_dout[DATA_W-1:0];
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (tx_push & ~tx_pop) tx_cnt <= tx_cnt + 1'b1;
      if (~tx_push & tx_pop) tx_cnt <= tx_cnt - 1'b1;
      if (rx_push & ~rx_pop) rx_cnt <= rx_cnt + 1'b1;
      if (~rx_push & rx_pop) rx_cnt <= rx_cnt - 1'b1;
    end
  end

  logic [31:0] status, rdata;

  always_comb begin
    status        = '0;
    status[0]     = tx_empty;
    status[1]     = tx_full;
    status[2]     = rx_empty;
    status[3]     = rx_full;
    status[4]     = tx_ovf;
    status[5]     = rx_ovf;
    status[15:8]  = 8'(tx_cnt);
    status[23:16] = 8'(rx_cnt);
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_data: rdata = rx_empty ? '0 : 32'(rx_mem[rx_rp]);
      hit_cmd:  rdata = 32'(cfg);
      hit_stat: rdata = status;
      default:  rdata = '0;
    endcase
  end

  logic tx_set, rx_set;
  assign tx_set = wr_data & tx_full & ~tx_pop;
  assign rx_set = rx_valid & rx_full & ~rx_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ack <= 1'b0;
      wb_din <= '0;
      cfg    <= '0;
      cfg_wr <= 1'b0;
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      wb_ack <= acc;
      cfg_wr <= wr_cmd;
      if (wr_cmd) cfg <= wb_dout[CMD_W-1:0];
      if (acc) wb_din <= wb_we ? '0 : rdata;
      // Set wins over a same-edge STATUS-read clear
      tx_ovf <= tx_set | (tx_ovf & ~rd_stat);
      rx_ovf <= rx_set | (rx_ovf & ~rd_stat);
    end
  end

  logic unused_ok;
  assign unused_ok = ^wb_dout;

endmodule
